// File: rtl/vga_pout_if.sv
// Line-FIFO read port between the line buffer and the pixel output stage.
// The output stage connects through the slave modport; the FIFO side uses master.
interface vga_pout_if #(
    parameter int CW = 8
);
    logic              fifo_empty_i;
    logic [3*CW-1:0]   fifo_q_i;
    logic              rreq_o;

    modport master (
        output fifo_empty_i,
        output fifo_q_i,
        input  rreq_o
    );

    modport slave (
        input  fifo_empty_i,
        input  fifo_q_i,
        output rreq_o
    );
endinterface

// File: rtl/vga_pout_stage.sv
// VGA/LCD pixel-clock output stage: FIFO read, sync/blank polarity, underrun handling.
// Optional: define VGA_POUT_HOLDLAST_EN to repeat the last valid pixel on underrun instead of black.
module vga_pout_stage #(
    parameter int CW   = 8,
    parameter int XDLY = 0,
    parameter int UCW  = 16
) (
    input  logic           clk_p_i,
    input  logic           arst,
    input  logic           ctrl_ven,
    input  logic           pol_hs,
    input  logic           pol_vs,
    input  logic           pol_cs,
    input  logic           pol_bl,
    input  logic           ihsync,
    input  logic           ivsync,
    input  logic           icsync,
    input  logic           iblank,
    input  logic           gate_i,
    vga_pout_if.slave      fifo,
    output logic           hsync_pad_o,
    output logic           vsync_pad_o,
    output logic           csync_pad_o,
    output logic           blank_pad_o,
    output logic [CW-1:0]  r_pad_o,
    output logic [CW-1:0]  g_pad_o,
    output logic [CW-1:0]  b_pad_o,
    output logic           luint_o,
    output logic [UCW-1:0] ucnt_o,
    input  logic           ucnt_clr_i
);

    localparam int PW = 3*CW + 4;

    logic            uc;
    logic            s1_hs, s1_vs, s1_cs, s1_bl;
    logic            s1_gate, s1_uc;
    logic [3*CW-1:0] sub_rgb;
    logic [3*CW-1:0] sel_rgb;
    logic [PW-1:0]   dl_in;
    logic [PW-1:0]   dl_out;

    assign uc = gate_i & fifo.fifo_empty_i & ctrl_ven;

    // Gated by arst so no read request leaks out while the pipeline is held in reset.
    assign fifo.rreq_o = arst & gate_i & ~fifo.fifo_empty_i & ctrl_ven;

    always_ff @(posedge clk_p_i or negedge arst) begin
        if (!arst) begin
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_cs   <= 1'b0;
            s1_bl   <= 1'b0;
            s1_gate <= 1'b0;
            s1_uc   <= 1'b0;
        end else begin
            s1_hs   <= ihsync & ctrl_ven;
            s1_vs   <= ivsync & ctrl_ven;
            s1_cs   <= icsync & ctrl_ven;
            s1_bl   <= iblank | ~ctrl_ven;
            s1_gate <= gate_i & ctrl_ven;
            s1_uc   <= uc;
        end
    end

`ifdef VGA_POUT_HOLDLAST_EN
    logic [3*CW-1:0] hold_rgb;

    always_ff @(posedge clk_p_i or negedge arst) begin
        if (!arst) begin
            hold_rgb <= '0;
        end else if (s1_gate && !s1_uc) begin
            hold_rgb <= fifo.fifo_q_i;
        end
    end

    assign sub_rgb = hold_rgb;
`else
    assign sub_rgb = '0;
`endif

    always_comb begin
        sel_rgb = '0;
        if (s1_gate) begin
            sel_rgb = s1_uc ? sub_rgb : fifo.fifo_q_i;
        end
    end

    assign dl_in = {s1_hs, s1_vs, s1_cs, s1_bl, sel_rgb};

    generate
        if (XDLY == 0) begin : g_nodly
            assign dl_out = dl_in;
        end else begin : g_dly
            logic [PW-1:0] dly [XDLY];

            always_ff @(posedge clk_p_i or negedge arst) begin
                if (!arst) begin
                    for (int i = 0; i < XDLY; i++) begin
                        dly[i] <= '0;
                    end
                end else begin
                    dly[0] <= dl_in;
                    for (int i = 1; i < XDLY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign dl_out = dly[XDLY-1];
        end
    endgenerate

    // Polarity is applied only here so a polarity change bypasses the delay line.
    always_ff @(posedge clk_p_i or negedge arst) begin
        if (!arst) begin
            hsync_pad_o <= 1'b0;
            vsync_pad_o <= 1'b0;
            csync_pad_o <= 1'b0;
            blank_pad_o <= 1'b0;
            r_pad_o     <= '0;
            g_pad_o     <= '0;
            b_pad_o     <= '0;
        end else begin
            hsync_pad_o <= dl_out[PW-1] ^ pol_hs;
            vsync_pad_o <= dl_out[PW-2] ^ pol_vs;
            csync_pad_o <= dl_out[PW-3] ^ pol_cs;
            blank_pad_o <= dl_out[PW-4] ^ pol_bl;
            r_pad_o     <= dl_out[3*CW-1 -: CW];
            g_pad_o     <= dl_out[2*CW-1 -: CW];
            b_pad_o     <= dl_out[CW-1:0];
        end
    end

    // s1_uc holds last cycle's uc, so this flags the first cycle of each underrun run.
    always_ff @(posedge clk_p_i or negedge arst) begin
        if (!arst) begin
            luint_o <= 1'b0;
        end else begin
            luint_o <= uc & ~s1_uc;
        end
    end

    always_ff @(posedge clk_p_i or negedge arst) begin
        if (!arst) begin
            ucnt_o <= '0;
        end else if (ucnt_clr_i) begin
            ucnt_o <= '0;
        end else if (uc && (ucnt_o != {UCW{1'b1}})) begin
            ucnt_o <= ucnt_o + {{(UCW-1){1'b0}}, 1'b1};
        end
    end

endmodule
